// File: rtl/hazard_stall_sched_if.sv
// Decode/EXE/MEM side-band bundle for the hazard and stall scheduler.
// master = pipeline that drives the usage/destination info; slave = scheduler.
interface hazard_stall_sched_if;
  logic        forward_en;
  logic [3:0]  src1_HZRD;
  logic [3:0]  src2_HZRD;
  logic        two_src_HZRD;
  logic        move_HZRD;
  logic [3:0]  dest_EXE;
  logic        WB_EN_EXE;
  logic        MEM_R_EN_EXE;
  logic [3:0]  dest_MEM;
  logic        WB_EN_MEM;
  logic        mem_req_MEM;
  logic        mem_ready;
  logic        B_EXE;
  logic        hazard;
  logic        freeze;
  logic        flush_IF;
  logic        mem_timeout;
  logic [31:0] stall_cycles;
  logic [31:0] bubble_cycles;
  logic [31:0] flush_count;

  modport master (
    output forward_en, src1_HZRD, src2_HZRD, two_src_HZRD, move_HZRD,
           dest_EXE, WB_EN_EXE, MEM_R_EN_EXE, dest_MEM, WB_EN_MEM,
           mem_req_MEM, mem_ready, B_EXE,
    input  hazard, freeze, flush_IF, mem_timeout,
           stall_cycles, bubble_cycles, flush_count
  );

  modport slave (
    input  forward_en, src1_HZRD, src2_HZRD, two_src_HZRD, move_HZRD,
           dest_EXE, WB_EN_EXE, MEM_R_EN_EXE, dest_MEM, WB_EN_MEM,
           mem_req_MEM, mem_ready, B_EXE,
    output hazard, freeze, flush_IF, mem_timeout,
           stall_cycles, bubble_cycles, flush_count
  );
endinterface

// File: rtl/hazard_stall_sched.sv
// Load-use/RAW bubble, memory-wait freeze and branch flush scheduler for the 5-stage core.
// Optional perf counters enabled by defining PERF_CNT_EN.
module hazard_stall_sched #(
  parameter int MAX_WAIT = 64,
  parameter int WAIT_W   = 8
) (
  input logic                  clk,
  input logic                  rst,
  hazard_stall_sched_if.slave  sif
);

  localparam int NUM_SRC = 2;
  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  // Index 0 = Rn, index 1 = Rm/Rd-of-store
  logic [NUM_SRC-1:0][3:0] src;
  logic [NUM_SRC-1:0]      src_rd;
  logic [NUM_SRC-1:0]      hit_exe;
  logic [NUM_SRC-1:0]      hit_mem;
  logic                    exe_hz, mem_hz;

  assign src    = {sif.src2_HZRD, sif.src1_HZRD};
  assign src_rd = {sif.two_src_HZRD, ~sif.move_HZRD};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign hit_exe[i] = src_rd[i] & (src[i] == sif.dest_EXE);
    assign hit_mem[i] = src_rd[i] & (src[i] == sif.dest_MEM);
  end

  // With forwarding only a load in EXE cannot be bypassed in time
  assign exe_hz = (|hit_exe) & (sif.forward_en ? sif.MEM_R_EN_EXE : sif.WB_EN_EXE);
  assign mem_hz = (|hit_mem) & sif.WB_EN_MEM & ~sif.forward_en;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              tmo_q, tmo_d;
  logic              frz_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    tmo_d   = tmo_q;
    frz_raw = 1'b0;
    case (state_q)
      RUN: begin
        if (sif.mem_req_MEM & ~sif.mem_ready) begin
          frz_raw = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (sif.mem_ready) begin
          state_d = RUN;
          wait_d  = '0;
        end else begin
          frz_raw = 1'b1;
          if (wait_q != '1) wait_d = wait_q + WAIT_W'(1);
          if (wait_q == MAX_CNT) tmo_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  logic hazard_o, freeze_o, flush_o;

  // Outputs are forced quiet while reset is held
  assign hazard_o = ~rst & (exe_hz | mem_hz);
  assign freeze_o = ~rst & frz_raw;
  assign flush_o  = ~rst & sif.B_EXE & ~frz_raw;

  assign sif.hazard      = hazard_o;
  assign sif.freeze      = freeze_o;
  assign sif.flush_IF    = flush_o;
  assign sif.mem_timeout = tmo_q;

`ifdef PERF_CNT_EN
  logic [31:0] stall_q, bubble_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if (freeze_o)             stall_q  <= stall_q + 32'd1;
      if (hazard_o & ~freeze_o) bubble_q <= bubble_q + 32'd1;
      if (flush_o)              flush_q  <= flush_q + 32'd1;
    end
  end

  assign sif.stall_cycles  = stall_q;
  assign sif.bubble_cycles = bubble_q;
  assign sif.flush_count   = flush_q;
`else
  assign sif.stall_cycles  = '0;
  assign sif.bubble_cycles = '0;
  assign sif.flush_count   = '0;
`endif

endmodule

// File: doc/hazard_stall_sched.md
Name: hazard_stall_sched

Overview:
Pipeline scheduler for the 5-stage ARM32 core. Generates the load-use/RAW bubble request to the decode stage, freezes the pipeline while the cache/SRAM path is not ready, and issues the fetch flush on a taken branch. Sits beside the decode stage and takes register-usage info from decode and stage-tagged destinations from EXE/MEM.

Parameters:
MAX_WAIT, 64, memory-wait cycles before the sticky timeout flag sets (≥2)
WAIT_W, 8, width of the wait counter (2^WAIT_W > MAX_WAIT)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
forward_en  in  1  forwarding unit enabled
src1_HZRD  in  4  decode source 1 (Rn)
src2_HZRD  in  4  decode source 2 (Rm, or Rd for stores)
two_src_HZRD  in  1  source 2 is read
move_HZRD  in  1  source 1 unused (MOV/MVN)
dest_EXE  in  4  EXE-stage destination
WB_EN_EXE  in  1  EXE-stage writes back
MEM_R_EN_EXE  in  1  EXE-stage is a load
dest_MEM  in  4  MEM-stage destination
WB_EN_MEM  in  1  MEM-stage writes back
mem_req_MEM  in  1  MEM-stage load/store present
mem_ready  in  1  cache/SRAM completes access this cycle
B_EXE  in  1  taken branch in EXE
hazard  out  1  bubble request to decode (freezes PC and IF/ID)
freeze  out  1  memory stall, freezes every pipeline register
flush_IF  out  1  clears IF/ID register
mem_timeout  out  1  sticky memory-wait timeout
stall_cycles  out  32  perf counter (see Optional Feature)
bubble_cycles  out  32  perf counter
flush_count  out  32  perf counter

Behaviour:
- Reset: the first clk edge with rst high forces state=RUN, wait_cnt=0, mem_timeout=0, counters=0. While rst is high, hazard/freeze/flush_IF are 0.
- s1_hit = ~move_HZRD & src1_HZRD==X. s2_hit = two_src_HZRD & src2_HZRD==X.
- forward_en=0: hazard = (s1_hit|s2_hit) for X=dest_EXE & WB_EN_EXE, or for X=dest_MEM & WB_EN_MEM.
- forward_en=1: hazard = (s1_hit|s2_hit) for X=dest_EXE & MEM_R_EN_EXE only (load-use).
- hazard is combinational, same cycle. It holds while the condition holds. The bench counts one bubble per asserted unfrozen cycle.
- States RUN, MEM_WAIT (registered, 1 bit).
- RUN: mem_req_MEM & ~mem_ready → freeze=1 this cycle, next state MEM_WAIT, wait_cnt←1. Otherwise freeze=0.
- MEM_WAIT: freeze = ~mem_ready. On mem_ready: freeze=0 this cycle, next state RUN, wait_cnt←0. Otherwise wait_cnt saturating increment.
- wait_cnt==MAX_WAIT with mem_ready=0 → mem_timeout←1, sticky until rst. State stays MEM_WAIT.
- A single-cycle access (mem_req_MEM & mem_ready in RUN) causes no freeze.
- flush_IF = B_EXE & ~freeze. A branch seen during freeze is held by frozen registers and flushes on the release cycle.
- hazard is still computed during freeze. The frozen pipeline masks it.
- Simultaneous branch and hazard: both asserted. The flush wins at IF/ID, and the fetch unit prioritises the branch target over PC hold.
- rst during MEM_WAIT: next cycle is RUN, with no freeze and no flush regardless of mem_ready.

Optional Feature:
PERF_CNT_EN defined:
- stall_cycles +1 each cycle freeze=1.
- bubble_cycles +1 each cycle hazard & ~freeze.
- flush_count +1 each cycle flush_IF=1.
- All counters are 32-bit, wrap at 2^32, and clear on rst.

PERF_CNT_EN undefined: the three outputs are constant 0 and no counter flops are synthesised.

Test Plan:
- forward_en=0, src1=3, dest_EXE=3, WB_EN_EXE=1 → hazard=1 same cycle. Set move_HZRD=1 → hazard=0.
- forward_en=1, src2=5, two_src=1, dest_EXE=5, WB_EN_EXE=1, MEM_R_EN_EXE=0 → hazard=0. Set MEM_R_EN_EXE=1 → hazard=1.
- mem_req_MEM=1, mem_ready low 4 cycles then high → freeze=1 for exactly 4 cycles, 0 on the ready cycle. State returns to RUN. With PERF_CNT_EN, stall_cycles=4.
- B_EXE=1 in RUN → flush_IF=1 one cycle. B_EXE=1 while freeze=1 → flush_IF=0 until the release cycle, then 1.
- MAX_WAIT=8, mem_ready held 0 → mem_timeout rises after 8 wait cycles and stays 1 after mem_ready. Only rst clears it.
- rst pulsed mid-MEM_WAIT → next cycle freeze=0, mem_timeout=0, counters=0, state RUN.
